super_logic_chain: RTL and testbench
====================================

SUPER_LOGIC_CHAIN -- requirements
Module: super_logic_chain

Interface
REQ-001 Parameter NUM_LC, default 8: number of logic cells in the chain; legal range 1..32.
REQ-002 Parameter LUT_INIT [16*NUM_LC-1:0], default 0: 4-input LUT truth table per cell, cell i uses bits [16*i+15:16*i].
REQ-003 Parameter LC_ARITH [NUM_LC-1:0], default 0: cell i is in arithmetic mode when its bit is 1, and in LUT mode when 0.
REQ-004 Parameter LC_QDI_SEL [NUM_LC-1:0], default 0: selects the data input of cell i's flip-flop; 0 selects FZ[i], 1 selects LI bit 3 of cell i.
REQ-005 Parameter CARRY_SPLIT, default 0: cell index at which the carry chain is pipelined; 0 means no pipelining; legal range 0..NUM_LC-1.
REQ-006 QCK  input  1  clock; all state updates on its rising edge.
REQ-007 QRT  input  1  reset; asynchronous, active-low.
REQ-008 LI  input  4*NUM_LC  cell inputs; cell i uses LI[4*i+3:4*i].
REQ-009 CI  input  1  carry into cell 0.
REQ-010 QEN  input  1  flip-flop enable, shared by all cells.
REQ-011 QST  input  1  synchronous set, shared by all cells.
REQ-012 FZ  output  NUM_LC  combinational output of each cell.
REQ-013 AQZ  output  NUM_LC  registered output of each cell.
REQ-014 CO  output  1  combinational carry out of the last cell.
REQ-015 COQ  output  1  registered copy of CO.

Function
REQ-016 LUT mode: FZ[i] is the LUT_INIT bit for cell i at index {LI3,LI2,LI1,LI0}, and carry passes through unchanged (C[i+1] = C[i]).
REQ-017 Arithmetic mode: FZ[i] = LI0 ^ LI1 ^ C[i], and C[i+1] = majority(LI0, LI1, C[i]); LI2 and LI3 are ignored by the arithmetic path.
REQ-018 C[0] = CI, and CO = C[NUM_LC].
REQ-019 Carry with CARRY_SPLIT = 0: the chain is purely combinational from CI to CO, so FZ and CO respond in the same cycle.
REQ-020 Carry with CARRY_SPLIT = k > 0: C[k] is taken from the split register CSR, which loads C[k]-combinational when QEN is high.
- CO, and FZ of cells k and above, therefore lag the lower cells by one cycle.
- The user must align operands for the upper cells.
REQ-021 Cell flip-flop Q[i], on a rising QCK edge:
- QST = 1 gives Q = 1.
- Otherwise QEN = 1 gives Q = D.
- Otherwise Q holds.
- QST takes priority over QEN.
REQ-022 D[i] = FZ[i] when LC_QDI_SEL[i] = 0, and LI[4*i+3] when LC_QDI_SEL[i] = 1.
REQ-023 AQZ[i] = Q[i], with a clock-to-out latency of one cycle from D.
REQ-024 COQ and CSR follow the same QST/QEN rule as the cell flip-flops.
- QST sets COQ to 1.
- QST clears CSR to 0, because the carry split must not inject a false carry.
REQ-025 QST and QEN asserted in the same cycle: every register takes its QST value.
REQ-026 Parameters outside their legal ranges are rejected at elaboration (fatal error).

Reset
REQ-027 QRT low asynchronously forces all Q[i], COQ and CSR to 0, independent of QCK.
REQ-028 While QRT is low, FZ and CO remain combinational and valid, computed with CSR = 0.
REQ-029 QRT released with no QCK edge: outputs hold 0 until the first enabled edge.
REQ-030 QRT asserted mid-operation, including during a split carry: the pending carry is discarded, with no glitch beyond the asynchronous clear.

Verification
REQ-031 8-bit adder: NUM_LC=8, LC_ARITH=8'hFF, CARRY_SPLIT=0, A=8'hFF, B=8'h01, CI=0 -> FZ=8'h00 and CO=1 combinationally; after one QEN edge, AQZ=8'h00 and COQ=1.
REQ-032 LUT mode: LUT_INIT for cell 0 = 16'h8000 (AND4), LI0=4'hF -> FZ[0]=1; LI0=4'hE -> FZ[0]=0.
REQ-033 Split carry: CARRY_SPLIT=4, all cells arithmetic, adding 8'h0F + 8'h01 with CI=0.
- The upper nibble carry reaches FZ[7:4] one cycle later.
- With the upper operand held, FZ = 8'h10 on cycle 2.
REQ-034 Priority: QST=1 and QEN=1 with D=0 -> AQZ=all ones and COQ=1 after the edge; QEN=0 with QST=0 -> AQZ holds across 3 edges.
REQ-035 Reset: drive AQZ to 8'hA5, then pull QRT low between edges -> AQZ=0, COQ=0 and CSR=0 immediately; release QRT -> the values hold until the next enabled edge.
REQ-036 Bypass: LC_QDI_SEL=8'hFF, LI3 bits = 8'h3C, QEN=1 -> AQZ=8'h3C after one edge, regardless of LUT_INIT.

Source files
------------

// File: rtl/super_logic_chain.sv
// super_logic_chain: chain of NUM_LC configurable logic cells.
// Each cell is either a 4-input LUT or a 1-bit full adder, drives a
// combinational output and a registered output, and passes a ripple carry
// to the next cell. The carry can optionally be pipelined at one cell
// boundary (CARRY_SPLIT) to shorten the combinational path.
//
// Ports:
//   QCK  clock, rising edge
//   QRT  asynchronous active-low reset (clears cell FFs, COQ, split register)
//   LI   4 inputs per cell, cell i uses LI[4*i+3:4*i]
//   CI   carry into cell 0
//   QEN  register enable shared by all cells
//   QST  synchronous set, wins over QEN
//   FZ   combinational output per cell
//   AQZ  registered output per cell
//   CO   combinational carry out of the last cell
//   COQ  registered CO

// One logic cell: LUT/adder function plus its output flip-flop.
module slc_cell #(
  parameter logic [15:0] LUT     = 16'h0000,
  parameter logic        ARITH   = 1'b0,
  parameter logic        QDI_SEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       st,
  input  logic [3:0] li,
  input  logic       cin,
  output logic       fz,
  output logic       cout,
  output logic       q
);

  logic d;

  always_comb begin
    fz   = LUT[li];
    cout = cin;
    if (ARITH) begin
      fz   = li[0] ^ li[1] ^ cin;
      cout = (li[0] & li[1]) | (li[0] & cin) | (li[1] & cin);
    end
  end

  // Bypass path lets the FF capture LI3 directly, independent of the LUT.
  assign d = QDI_SEL ? li[3] : fz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (st)  q <= 1'b1;
    else if (en)  q <= d;
  end

endmodule

module super_logic_chain #(
  parameter int                     NUM_LC      = 8,
  parameter logic [16*NUM_LC-1:0]   LUT_INIT    = '0,
  parameter logic [NUM_LC-1:0]      LC_ARITH    = '0,
  parameter logic [NUM_LC-1:0]      LC_QDI_SEL  = '0,
  parameter int                     CARRY_SPLIT = 0
) (
  input  logic                  QCK,
  input  logic                  QRT,
  input  logic [4*NUM_LC-1:0]   LI,
  input  logic                  CI,
  input  logic                  QEN,
  input  logic                  QST,
  output logic [NUM_LC-1:0]     FZ,
  output logic [NUM_LC-1:0]     AQZ,
  output logic                  CO,
  output logic                  COQ
);

  if (NUM_LC < 1 || NUM_LC > 32) begin : g_bad_num_lc
    $fatal(1, "super_logic_chain: NUM_LC must be in 1..32");
  end
  if (CARRY_SPLIT < 0 || CARRY_SPLIT > NUM_LC - 1) begin : g_bad_split
    $fatal(1, "super_logic_chain: CARRY_SPLIT must be in 0..NUM_LC-1");
  end

  // c_comb[i] is the combinational carry arriving at cell i from below;
  // c_in[i] is what cell i actually consumes (split register at the split).
  logic [NUM_LC:0]   c_comb;
  logic [NUM_LC-1:0] c_in;
  logic              csr;

  assign c_comb[0] = CI;
  assign CO        = c_comb[NUM_LC];

  for (genvar i = 0; i < NUM_LC; i++) begin : g_lc
    assign c_in[i] = (CARRY_SPLIT != 0 && i == CARRY_SPLIT) ? csr : c_comb[i];

    slc_cell #(
      .LUT     (LUT_INIT[16*i +: 16]),
      .ARITH   (LC_ARITH[i]),
      .QDI_SEL (LC_QDI_SEL[i])
    ) u_cell (
      .clk   (QCK),
      .rst_n (QRT),
      .en    (QEN),
      .st    (QST),
      .li    (LI[4*i +: 4]),
      .cin   (c_in[i]),
      .fz    (FZ[i]),
      .cout  (c_comb[i+1]),
      .q     (AQZ[i])
    );
  end

  // Split register clears on QST rather than setting: a set here would
  // inject a phantom carry into the upper cells. With CARRY_SPLIT = 0 it
  // has no reader and is trimmed away.
  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT)      csr <= 1'b0;
    else if (QST)  csr <= 1'b0;
    else if (QEN)  csr <= c_comb[CARRY_SPLIT];
  end

  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT)      COQ <= 1'b0;
    else if (QST)  COQ <= 1'b1;
    else if (QEN)  COQ <= CO;
  end

endmodule

// File: tb/tb_super_logic_chain.sv
// Bench for super_logic_chain: four instances (plain adder, LUT chain,
// split-carry adder, FF bypass) share clock, reset, QEN and QST.
// Expected values are queued when stimulus is driven and compared when
// the outputs are sampled.
module tb_super_logic_chain;

  localparam logic [127:0] LUT_L = {16'h1234, 16'hBEEF, 16'h0F0F, 16'hCAFE,
                                    16'hA5A5, 16'hFFFE, 16'h6996, 16'h8000};
  localparam logic [127:0] LUT_ONES = {128{1'b1}};

  logic QCK = 1'b0, QRT = 1'b0, QEN = 1'b0, QST = 1'b0;
  logic [31:0] add_li = '0, lut_li = '0, spl_li = '0, byp_li = '0;
  logic        add_ci = 1'b0, lut_ci = 1'b0, spl_ci = 1'b0, byp_ci = 1'b0;
  logic [7:0]  add_fz, add_aqz, lut_fz, lut_aqz, spl_fz, spl_aqz, byp_fz, byp_aqz;
  logic        add_co, add_coq, lut_co, lut_coq, spl_co, spl_coq, byp_co, byp_coq;

  always #5 QCK = ~QCK;

  super_logic_chain #(.NUM_LC(8), .LUT_INIT('0), .LC_ARITH(8'hFF),
                      .LC_QDI_SEL(8'h00), .CARRY_SPLIT(0)) u_add (
    .QCK(QCK), .QRT(QRT), .LI(add_li), .CI(add_ci), .QEN(QEN), .QST(QST),
    .FZ(add_fz), .AQZ(add_aqz), .CO(add_co), .COQ(add_coq));

  super_logic_chain #(.NUM_LC(8), .LUT_INIT(LUT_L), .LC_ARITH(8'h00),
                      .LC_QDI_SEL(8'h00), .CARRY_SPLIT(0)) u_lut (
    .QCK(QCK), .QRT(QRT), .LI(lut_li), .CI(lut_ci), .QEN(QEN), .QST(QST),
    .FZ(lut_fz), .AQZ(lut_aqz), .CO(lut_co), .COQ(lut_coq));

  super_logic_chain #(.NUM_LC(8), .LUT_INIT('0), .LC_ARITH(8'hFF),
                      .LC_QDI_SEL(8'h00), .CARRY_SPLIT(4)) u_spl (
    .QCK(QCK), .QRT(QRT), .LI(spl_li), .CI(spl_ci), .QEN(QEN), .QST(QST),
    .FZ(spl_fz), .AQZ(spl_aqz), .CO(spl_co), .COQ(spl_coq));

  super_logic_chain #(.NUM_LC(8), .LUT_INIT(LUT_ONES), .LC_ARITH(8'h00),
                      .LC_QDI_SEL(8'hFF), .CARRY_SPLIT(0)) u_byp (
    .QCK(QCK), .QRT(QRT), .LI(byp_li), .CI(byp_ci), .QEN(QEN), .QST(QST),
    .FZ(byp_fz), .AQZ(byp_aqz), .CO(byp_co), .COQ(byp_coq));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // split-adder model state
  logic [7:0] spl_a = '0, spl_b = '0;
  logic       csr_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      0:  return 32'(add_fz);
      1:  return 32'(add_co);
      2:  return 32'(add_aqz);
      3:  return 32'(add_coq);
      4:  return 32'(lut_fz);
      5:  return 32'(lut_co);
      6:  return 32'(spl_fz);
      7:  return 32'(spl_co);
      8:  return 32'(byp_aqz);
      9:  return 32'(spl_aqz);
      10: return 32'(lut_aqz);
      11: return 32'(lut_fz[0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_of(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] pack_ab(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] l3);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i]   = a[i];
      r[4*i+1] = b[i];
      r[4*i+3] = l3[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] lut_model(input logic [31:0] li);
    logic [127:0] t;
    logic [7:0]   r;
    int           idx;
    t = LUT_L;
    for (int i = 0; i < 8; i++) begin
      idx  = 16*i + int'(li[4*i +: 4]);
      r[i] = t[idx];
    end
    return r;
  endfunction

  // {co, fz} of the split adder given the split register value
  function automatic logic [8:0] spl_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic ci, input logic csr);
    logic [4:0] lo, hi;
    lo = 5'(a[3:0]) + 5'(b[3:0]) + 5'(ci);
    hi = 5'(a[7:4]) + 5'(b[7:4]) + 5'(csr);
    return {hi[4], hi[3:0], lo[3:0]};
  endfunction

  function automatic logic spl_lo_carry(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci);
    logic [4:0] lo;
    lo = 5'(a[3:0]) + 5'(b[3:0]) + 5'(ci);
    return lo[4];
  endfunction

  // one clock edge; the split-register model advances with it
  task automatic tick();
    logic nxt;
    nxt = csr_m;
    if (QST)      nxt = 1'b0;
    else if (QEN) nxt = spl_lo_carry(spl_a, spl_b, spl_ci);
    @(posedge QCK);
    if (QRT) csr_m = nxt;
    #1;
  endtask

  task automatic set_spl(input logic [7:0] a, input logic [7:0] b, input logic ci);
    spl_a = a; spl_b = b; spl_ci = ci;
    spl_li = pack_ab(a, b, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a, b;
    logic        ci;
    logic [8:0]  s;
    logic [31:0] li;

    // ---- reset state, combinational path alive during reset
    #2;
    want("rst_add_aqz", 2, 32'h0);
    want("rst_add_coq", 3, 32'h0);
    want("rst_lut_aqz", 10, 32'h0);
    want("rst_spl_aqz", 9, 32'h0);
    add_li = pack_ab(8'hFF, 8'h01, 8'h00); add_ci = 1'b0;
    #1;
    want("rst_add_fz", 0, 32'h00);
    want("rst_add_co", 1, 32'h1);
    drain();
    QRT = 1'b1;                     // released before any edge

    // ---- no enabled edge yet: outputs hold 0
    QEN = 1'b0;
    tick();
    want("rel_hold_aqz", 2, 32'h0);
    want("rel_hold_coq", 3, 32'h0);
    drain();

    // ---- 8-bit adder FF + 01
    QEN = 1'b1;
    want("add_ff01_aqz", 2, 32'h00);
    want("add_ff01_coq", 3, 32'h1);
    tick();
    drain();

    // ---- random adder vectors
    for (int n = 0; n < 6; n++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      add_li = pack_ab(a, b, 8'($urandom)); add_ci = ci;
      s = 9'(a) + 9'(b) + 9'(ci);
      #1;
      want("add_rnd_fz", 0, 32'(s[7:0]));
      want("add_rnd_co", 1, 32'(s[8]));
      drain();
      want("add_rnd_aqz", 2, 32'(s[7:0]));
      want("add_rnd_coq", 3, 32'(s[8]));
      tick();
      drain();
    end

    // ---- QST beats QEN, D = 0
    add_li = pack_ab(8'h00, 8'h00, 8'h00); add_ci = 1'b0;
    lut_li = '0; lut_ci = 1'b0;
    QST = 1'b1; QEN = 1'b1;
    want("pri_add_aqz", 2, 32'hFF);
    want("pri_add_coq", 3, 32'h1);
    want("pri_lut_aqz", 10, 32'hFF);
    tick();
    drain();
    QST = 1'b0; QEN = 1'b0;
    add_li = pack_ab(8'h12, 8'h34, 8'h00);
    for (int n = 0; n < 3; n++) begin
      want("hold_aqz", 2, 32'hFF);
      want("hold_coq", 3, 32'h1);
      tick();
      drain();
    end

    // ---- LUT chain: AND4 in cell 0, full model elsewhere
    lut_li = 32'h0000_000F; lut_ci = 1'b1;
    #1;
    want("and4_f", 11, 32'h1);
    want("lut_ci_pass", 5, 32'h1);
    drain();
    lut_li = 32'h0000_000E; lut_ci = 1'b0;
    #1;
    want("and4_e", 11, 32'h0);
    want("lut_ci_pass0", 5, 32'h0);
    drain();
    QEN = 1'b1;
    for (int n = 0; n < 5; n++) begin
      li = $urandom; lut_li = li; lut_ci = 1'($urandom);
      #1;
      want("lut_rnd_fz", 4, 32'(lut_model(li)));
      want("lut_rnd_co", 5, 32'(lut_ci));
      drain();
      want("lut_rnd_aqz", 10, 32'(lut_model(li)));
      tick();
      drain();
    end

    // ---- split carry: clear CSR, then 0F + 01
    set_spl(8'h00, 8'h00, 1'b0);
    QST = 1'b1;
    tick();
    QST = 1'b0; QEN = 1'b1;
    set_spl(8'h0F, 8'h01, 1'b0);
    #1;
    want("spl_c1_fz", 6, 32'h00);
    drain();
    tick();
    want("spl_c2_fz", 6, 32'h10);
    want("spl_c2_co", 7, 32'h0);
    drain();
    for (int n = 0; n < 6; n++) begin
      set_spl(8'($urandom), 8'($urandom), 1'($urandom));
      #1;
      s = spl_model(spl_a, spl_b, spl_ci, csr_m);
      want("spl_rnd_fz", 6, 32'(s[7:0]));
      want("spl_rnd_co", 7, 32'(s[8]));
      drain();
      tick();
    end

    // ---- async reset mid-operation with a carry pending in CSR
    add_li = pack_ab(8'hA5, 8'h00, 8'h00); add_ci = 1'b0;
    set_spl(8'h0F, 8'h01, 1'b0);
    QEN = 1'b1;
    tick();
    want("pre_rst_aqz", 2, 32'hA5);
    want("pre_rst_spl", 6, 32'h10);
    drain();
    #2;
    QRT = 1'b0;
    csr_m = 1'b0;
    #1;
    want("arst_aqz", 2, 32'h00);
    want("arst_coq", 3, 32'h0);
    want("arst_csr", 6, 32'h00);
    drain();
    QRT = 1'b1; QEN = 1'b0;
    #1;
    want("rel_aqz", 2, 32'h00);
    drain();
    tick();
    want("rel_edge_aqz", 2, 32'h00);
    want("rel_edge_csr", 6, 32'h00);
    drain();
    QEN = 1'b1;
    tick();
    want("reen_aqz", 2, 32'hA5);
    want("reen_spl", 6, 32'h10);
    drain();

    // ---- bypass: FF takes LI3, not the all-ones LUT
    byp_li = pack_ab(8'hFF, 8'hFF, 8'h3C);
    want("byp_3c", 8, 32'h3C);
    tick();
    drain();
    byp_li = pack_ab(8'h00, 8'hFF, 8'hC3);
    want("byp_c3", 8, 32'hC3);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
